hdmi_i2c_init: RTL

Sequencer that configures the ADV7511 HDMI transmitter on the KC705 after power-up. On `start`, it walks a fixed table of register writes and issues each one as an I2C write transaction (START, address, register, data, STOP) on the board I2C bus. It sits beside the HDMI timing/pattern path and drives the `i2c_scl`/`i2c_sda` pads, so the ADV7511 is powered up and set to 16-bit YCbCr 4:2:2 separate-sync input before `hdmiout_*` carries video.

---
 rtl/hdmi_i2c_pkg.sv | 34 +++
 rtl/adv7511_init_rom.sv | 36 +++
 rtl/hdmi_i2c_init.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_i2c_pkg
// Description : Shared types and constants for the ADV7511 I2C init sequencer.
//               Optional build macro used by the sequencer: HDMI_I2C_MUX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_BIT   = 4'd2,
        ST_ACK   = 4'd3,
        ST_STOP  = 4'd4,
        ST_GAP   = 4'd5,
        ST_NEXT  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } i2c_state_t;

    // Number of register writes in the ADV7511 init table
    localparam logic [4:0] NUM_REGS    = 5'd12;

    // Error index reported when the PCA9548 mux write is NACKed
    localparam logic [4:0] MUX_ERR_IDX = 5'd31;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } i2c_entry_t;

endpackage
`default_nettype wire

// File: rtl/adv7511_init_rom.sv
`default_nettype none
// ============================================================================
// Module      : adv7511_init_rom
// Description : Combinational lookup of the ADV7511 power-up register table.
//               Selects 16-bit YCbCr 4:2:2 input with separate syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module adv7511_init_rom
    import hdmi_i2c_pkg::*;
(
    input  logic [4:0] i_idx,
    output i2c_entry_t o_entry
);

    // Fixed table; indices past the end read as zero
    always_comb begin
        o_entry = '{reg_addr: 8'h00, data: 8'h00};
        case (i_idx)
            5'd0:    o_entry = '{reg_addr: 8'h41, data: 8'h10};
            5'd1:    o_entry = '{reg_addr: 8'h98, data: 8'h03};
            5'd2:    o_entry = '{reg_addr: 8'h9A, data: 8'hE0};
            5'd3:    o_entry = '{reg_addr: 8'h9C, data: 8'h30};
            5'd4:    o_entry = '{reg_addr: 8'h9D, data: 8'h61};
            5'd5:    o_entry = '{reg_addr: 8'hA2, data: 8'hA4};
            5'd6:    o_entry = '{reg_addr: 8'hA3, data: 8'hA4};
            5'd7:    o_entry = '{reg_addr: 8'hE0, data: 8'hD0};
            5'd8:    o_entry = '{reg_addr: 8'hF9, data: 8'h00};
            5'd9:    o_entry = '{reg_addr: 8'h15, data: 8'h01};
            5'd10:   o_entry = '{reg_addr: 8'h16, data: 8'hB5};
            5'd11:   o_entry = '{reg_addr: 8'hAF, data: 8'h06};
            default: o_entry = '{reg_addr: 8'h00, data: 8'h00};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_i2c_init.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_i2c_init
// Description : Power-up I2C write sequencer for the KC705 ADV7511 HDMI
//               transmitter. Walks the init table issuing START/addr/reg/data
//               /STOP writes. Define HDMI_I2C_MUX_EN to first select the HDMI
//               channel of the PCA9548 bus mux.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_i2c_init
    import hdmi_i2c_pkg::*;
#(
    parameter int         CLK_HZ   = 200_000_000,
    parameter int         SCL_HZ   = 100_000,
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter logic [6:0] MUX_ADDR = 7'h74,
    parameter logic [7:0] MUX_CHAN = 8'h20
)(
    input  logic       sys0_clk,
    input  logic       sys0_rstn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] err_idx,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int               c_q_div  = CLK_HZ / (4 * SCL_HZ);
    localparam int               c_q_w    = (c_q_div > 1) ? $clog2(c_q_div) : 1;
    localparam logic [c_q_w-1:0] c_q_last = c_q_w'(c_q_div - 1);

`ifdef HDMI_I2C_MUX_EN
    localparam logic c_mux_en = 1'b1;
`else
    localparam logic c_mux_en = 1'b0;
    logic w_unused_mux;
    assign w_unused_mux = ^{MUX_ADDR, MUX_CHAN};
`endif

    i2c_state_t       r_state;
    logic [c_q_w-1:0] r_qcnt;
    logic [1:0]       r_phase;
    logic [2:0]       r_bit;
    logic [1:0]       r_byte;
    logic [7:0]       r_shift;
    logic [4:0]       r_idx;
    logic             r_nack;
    logic             r_mux;

    logic             w_qtick;
    logic [1:0]       w_sel;
    logic [1:0]       w_last_byte;
    logic [7:0]       w_sel_byte;
    i2c_entry_t       w_entry;

    adv7511_init_rom u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_qtick     = (r_qcnt == c_q_last);
    // Byte to load: position 0 after START, next position after an ACK
    assign w_sel       = (r_state == ST_ACK) ? (r_byte + 2'd1) : 2'd0;
    assign w_last_byte = r_mux ? 2'd1 : 2'd2;

    // Select the byte transmitted at a given position of the current write
    always_comb begin
        w_sel_byte = {DEV_ADDR, 1'b0};
        case (w_sel)
            2'd1:    w_sel_byte = w_entry.reg_addr;
            2'd2:    w_sel_byte = w_entry.data;
            default: w_sel_byte = {DEV_ADDR, 1'b0};
        endcase
`ifdef HDMI_I2C_MUX_EN
        if (r_mux) begin
            w_sel_byte = (w_sel == 2'd0) ? {MUX_ADDR, 1'b0} : MUX_CHAN;
        end
`endif
    end

    // Free-running quarter-bit divider
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            r_qcnt <= '0;
        end else if (w_qtick) begin
            r_qcnt <= '0;
        end else begin
            r_qcnt <= r_qcnt + 1'b1;
        end
    end

    // Sequencer FSM: each bus phase is applied on a qtick, with the four
    // phases of a state taken in order before moving to the next state
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            r_state <= ST_IDLE;
            r_phase <= 2'd0;
            r_bit   <= 3'd0;
            r_byte  <= 2'd0;
            r_shift <= 8'h00;
            r_idx   <= 5'd0;
            r_nack  <= 1'b0;
            r_mux   <= 1'b0;
            scl_o   <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            err_idx <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    scl_o  <= 1'b1;
                    sda_oe <= 1'b0;
                    if (start) begin
                        done    <= 1'b0;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        r_idx   <= 5'd0;
                        r_nack  <= 1'b0;
                        r_phase <= 2'd0;
                        r_mux   <= c_mux_en;
                        r_state <= ST_START;
                    end
                end
                ST_START: if (w_qtick) begin
                    r_phase <= r_phase + 2'd1;
                    case (r_phase)
                        2'd0: begin scl_o <= 1'b1; sda_oe <= 1'b0; end
                        2'd1: sda_oe <= 1'b1;
                        2'd2: ;
                        default: begin
                            scl_o   <= 1'b0;
                            r_byte  <= 2'd0;
                            r_bit   <= 3'd0;
                            r_shift <= w_sel_byte;
                            r_state <= ST_BIT;
                        end
                    endcase
                end
                ST_BIT: if (w_qtick) begin
                    r_phase <= r_phase + 2'd1;
                    case (r_phase)
                        2'd0: begin scl_o <= 1'b0; sda_oe <= ~r_shift[7]; end
                        2'd1: scl_o <= 1'b1;
                        2'd2: ;
                        default: begin
                            scl_o   <= 1'b0;
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= ST_ACK;
                            end
                        end
                    endcase
                end
                ST_ACK: if (w_qtick) begin
                    r_phase <= r_phase + 2'd1;
                    case (r_phase)
                        2'd0: begin scl_o <= 1'b0; sda_oe <= 1'b0; end
                        2'd1: scl_o <= 1'b1;
                        2'd2: r_nack <= sda_i;
                        default: begin
                            scl_o <= 1'b0;
                            if (r_nack || (r_byte == w_last_byte)) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_byte  <= r_byte + 2'd1;
                                r_shift <= w_sel_byte;
                                r_state <= ST_BIT;
                            end
                        end
                    endcase
                end
                ST_STOP: if (w_qtick) begin
                    r_phase <= r_phase + 2'd1;
                    case (r_phase)
                        2'd0: sda_oe <= 1'b1;
                        2'd1: scl_o <= 1'b1;
                        2'd2: sda_oe <= 1'b0;
                        default: begin
                            if (r_nack) begin
                                error   <= 1'b1;
                                busy    <= 1'b0;
                                err_idx <= r_mux ? MUX_ERR_IDX : r_idx;
                                r_state <= ST_ERR;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end
                    endcase
                end
                ST_GAP: if (w_qtick) begin
                    r_phase <= r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // The mux write does not consume a table entry
                    if (r_mux) begin
                        r_mux   <= 1'b0;
                        r_state <= ST_START;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                        if ((r_idx + 5'd1) == NUM_REGS) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_START;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
